ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
Shares the N_PORTS CPU-side ports (we0..we3/addr0..addr3/d0..d3/q0..q3) of Unified_MultiPort_RAM among N_REQ requesters, such as PE lanes and load/store units.
- Each cycle it grants up to N_PORTS requests in round-robin order and drives them onto the RAM ports.
- It resolves same-address hazards within a cycle and returns registered read data one cycle after the grant.
- It sits between the requesters and the RAM instance; the GPU ports of the RAM are untouched.

Parameters:
N_REQ, 8, number of requesters (2..16)
N_PORTS, 4, number of RAM ports managed (1..4)
ADDR_W, 32, address width
DATA_W, 32, data width
CNT_W, 16, width of conflict counter

Ports:
clock  in  1  system clock, all state on posedge
reset  in  1  synchronous, active-high reset
req_valid  in  N_REQ  request pending per requester
req_we  in  N_REQ  1=write, 0=read
req_addr  in  N_REQ*ADDR_W  flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  N_REQ*DATA_W  flattened write data
req_ready  out  N_REQ  grant this cycle (combinational); transfer when valid&ready
resp_valid  out  N_REQ  read data valid, registered
resp_rdata  out  N_REQ*DATA_W  registered read data per requester
ram_en  out  1  RAM enable, 1 whenever not in reset
ram_we  out  N_PORTS  per-port write enable
ram_addr  out  N_PORTS*ADDR_W  per-port address
ram_d  out  N_PORTS*DATA_W  per-port write data
ram_q  in  N_PORTS*DATA_W  per-port combinational read data from RAM
conflict_count  out  CNT_W  saturating count of hazard-deferred requests

Behaviour:
- Registered state:
  - rr_ptr (clog2(N_REQ) bits)
  - resp_valid, resp_rdata, conflict_count
- Reset values (reset high at a posedge):
  - rr_ptr=0, resp_valid=0, resp_rdata=0, conflict_count=0
  - While reset is high: req_ready=0, ram_we=0, ram_en=0, ram_addr/ram_d=0.
- Grant selection (combinational, each cycle):
  - Scan requesters in order rr_ptr, rr_ptr+1, ... wrapping modulo N_REQ.
  - Take valid requests until N_PORTS are granted or the scan completes.
  - The k-th granted request, in scan order, drives RAM port k.
  - Unused ports: we=0, addr=0, d=0.
- Hazard rules, applied in scan order against already-granted requests in the same cycle:
  - Write after write, same address: the later write is not granted and stays pending.
  - Read after write, same address: the later read is not granted, so it never sees a same-edge write.
  - Write after read, same address: granted. The read samples the old value at the edge, which is legal.
  - Read after read, same address: both granted.
  - Each non-granted-by-hazard valid request increments conflict_count by 1; the counter saturates at all-ones.
- Handshake:
  - req_ready[i]=1 only if requester i is granted this cycle.
  - A requester must hold valid, we, addr and wdata stable until ready.
  - Writes commit at the grant edge.
- Reads:
  - At the grant edge, resp_rdata[i] <= ram_q[port k] and resp_valid[i] <= 1.
  - resp_valid[i] is 0 in any cycle after a non-read-grant. Latency is exactly 1 cycle.
- rr_ptr update at each edge:
  - If any grant occurred: rr_ptr <= (index of last granted requester + 1) mod N_REQ.
  - Otherwise rr_ptr holds.
  - This guarantees every requester is granted within ceil(N_REQ/N_PORTS)+1 cycles, provided its hazard clears.
- Boundaries:
  - All N_REQ valid: exactly N_PORTS grants.
  - N_PORTS >= N_REQ: all non-hazard requests granted.
  - rr_ptr wraps from N_REQ-1 to 0.
  - Reset mid-traffic: pending requests are dropped; requesters re-present them after reset.

Decomposition:
- Shared package ram_arb_pkg holds:
  - the ADDR_W/DATA_W defaults
  - the port-count constant (4), matching the RAM
  - a clog2 function
- One natural sub-module, rr_multi_grant: a rotating priority scan that outputs a grant vector and a port index per grant, with a hazard mask input.
- The top level handles hazard comparison, port muxing, response registers and the counter.

Test Plan:
1. Reset held 2 cycles with all req_valid=1 -> req_ready=0, ram_we=0, resp_valid=0, conflict_count=0.
2. N_REQ=8, N_PORTS=4, all reads to distinct addresses, rr_ptr=0:
   - cycle 1 grants 0..3, rr_ptr=4
   - cycle 2 grants 4..7, rr_ptr=0
   - resp_rdata[i] equals the preloaded mem[addr_i] one cycle after each grant.
3. Req0 writes 0xDEAD to 2048 and req1 writes 0xBEEF to 2048 in the same cycle -> req0 granted, req1 stalled, conflict_count=1; next cycle req1 granted, final mem[2048]=0xBEEF.
4. Req2 writes 5 to 4096 and req3 reads 4096, rr_ptr=2 -> read deferred one cycle, then resp_rdata[3]=5 and resp_valid[3]=1 exactly one cycle after its grant.
5. Only req7 valid with rr_ptr=0 -> granted on port 0; rr_ptr becomes 0 (wrap); then req0 and req7 both valid -> both granted in one cycle.
6. Force 65540 hazard deferrals with CNT_W=16 -> conflict_count saturates at 0xFFFF.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared constants and helpers for the multi-port RAM request arbiter.
// The port count matches the CPU-side port count of the shared RAM.
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int RAM_PORTS  = 4;

    // Ceiling log2, never below 1 so index vectors always have a legal width.
    function automatic int clog2(input int n);
        int r;
        for (r = 0; (1 << r) < n; r++) begin
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_multi_grant.sv
// Rotating-priority scan granting up to N_PORTS requesters per cycle.
// A requester is deferred when any already-granted requester is set in its hazard mask row.
module rr_multi_grant
    import ram_arb_pkg::*;
#(
    parameter int N_REQ   = 8,
    parameter int N_PORTS = RAM_PORTS,
    parameter int PTR_W   = clog2(N_REQ),
    parameter int PORT_W  = clog2(N_PORTS)
) (
    input  logic [N_REQ-1:0]        valid,
    input  logic [N_REQ*N_REQ-1:0]  hazard_mask,
    input  logic [PTR_W-1:0]        rr_ptr,
    output logic [N_REQ-1:0]        grant,
    output logic [N_REQ-1:0]        deferred,
    output logic [N_REQ*PORT_W-1:0] port_idx,
    output logic [PTR_W-1:0]        next_ptr,
    output logic                    any_grant
);

    int idx;
    int n_granted;

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        grant     = '0;
        deferred  = '0;
        port_idx  = '0;
        next_ptr  = rr_ptr;
        any_grant = 1'b0;
        n_granted = 0;
        idx       = 0;
        for (int s = 0; s < N_REQ; s++) begin
            idx = int'(rr_ptr) + s;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (valid[idx] && n_granted < N_PORTS) begin
                if (|(hazard_mask[idx*N_REQ +: N_REQ] & grant)) begin
                    deferred[idx] = 1'b1;
                end else begin
                    grant[idx]                        = 1'b1;
                    port_idx[idx*PORT_W +: PORT_W]    = PORT_W'(n_granted);
                    n_granted                         = n_granted + 1;
                    any_grant                         = 1'b1;
                    next_ptr = (idx == N_REQ - 1) ? '0 : PTR_W'(idx + 1);
                end
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the CPU-side ports of the multi-port RAM among N_REQ requesters with
// same-cycle hazard resolution and registered one-cycle read responses.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int N_REQ   = 8,
    parameter int N_PORTS = RAM_PORTS,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CNT_W   = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_we,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          resp_valid,
    output logic [N_REQ*DATA_W-1:0]   resp_rdata,
    output logic                      ram_en,
    output logic [N_PORTS-1:0]        ram_we,
    output logic [N_PORTS*ADDR_W-1:0] ram_addr,
    output logic [N_PORTS*DATA_W-1:0] ram_d,
    input  logic [N_PORTS*DATA_W-1:0] ram_q,
    output logic [CNT_W-1:0]          conflict_count
);

    localparam int PTR_W  = clog2(N_REQ);
    localparam int PORT_W = clog2(N_PORTS);
    localparam int SUM_W  = CNT_W + 5;

    logic [PTR_W-1:0]        rr_ptr;
    logic [N_REQ*N_REQ-1:0]  hazard_mask;
    logic [N_REQ-1:0]        grant;
    logic [N_REQ-1:0]        granted;
    logic [N_REQ-1:0]        deferred;
    logic [N_REQ*PORT_W-1:0] port_idx;
    logic [PTR_W-1:0]        next_ptr;
    logic                    any_grant;
    logic [PORT_W-1:0]       p;
    logic [SUM_W-1:0]        cnt_sum;

    // Only an earlier granted write to the same address blocks a later request.
    always_comb begin
        hazard_mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (i != j) begin
                    hazard_mask[i*N_REQ + j] = req_we[j] &&
                        (req_addr[i*ADDR_W +: ADDR_W] == req_addr[j*ADDR_W +: ADDR_W]);
                end
            end
        end
    end

    rr_multi_grant #(
        .N_REQ   (N_REQ),
        .N_PORTS (N_PORTS),
        .PTR_W   (PTR_W),
        .PORT_W  (PORT_W)
    ) u_scan (
        .valid       (req_valid),
        .hazard_mask (hazard_mask),
        .rr_ptr      (rr_ptr),
        .grant       (grant),
        .deferred    (deferred),
        .port_idx    (port_idx),
        .next_ptr    (next_ptr),
        .any_grant   (any_grant)
    );

    assign granted   = reset ? '0 : grant;
    assign req_ready = granted;
    assign ram_en    = ~reset;

    always_comb begin
        ram_we   = '0;
        ram_addr = '0;
        ram_d    = '0;
        p        = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (granted[i]) begin
                p                             = port_idx[i*PORT_W +: PORT_W];
                ram_we[p]                     = req_we[i];
                ram_addr[p*ADDR_W +: ADDR_W]  = req_addr[i*ADDR_W +: ADDR_W];
                ram_d[p*DATA_W +: DATA_W]     = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign cnt_sum = SUM_W'(conflict_count) + SUM_W'($countones(deferred));

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr         <= '0;
            resp_valid     <= '0;
            resp_rdata     <= '0;
            conflict_count <= '0;
        end else begin
            if (any_grant) rr_ptr <= next_ptr;
            for (int i = 0; i < N_REQ; i++) begin
                resp_valid[i] <= granted[i] & ~req_we[i];
                if (granted[i] && !req_we[i]) begin
                    resp_rdata[i*DATA_W +: DATA_W] <=
                        ram_q[port_idx[i*PORT_W +: PORT_W]*DATA_W +: DATA_W];
                end
            end
            conflict_count <= (cnt_sum > SUM_W'({CNT_W{1'b1}})) ? '1 : cnt_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench: table-driven grant vectors, hand-written hazard/wrap/reset
// sequences, and a read-response scoreboard backed by a behavioural RAM.
module tb_ram_port_arbiter;

    localparam int NR = 8;
    localparam int NP = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 16;

    logic             clock;
    logic             reset;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_we;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    resp_valid;
    logic [NR*DW-1:0] resp_rdata;
    logic             ram_en;
    logic [NP-1:0]    ram_we;
    logic [NP*AW-1:0] ram_addr;
    logic [NP*DW-1:0] ram_d;
    logic [NP*DW-1:0] ram_q;
    logic [CW-1:0]    conflict_count;

    logic [31:0] addr_a  [NR];
    logic [31:0] wdata_a [NR];
    logic [31:0] mem [8192];
    logic        preload;

    typedef struct packed {
        logic [7:0]  valid;
        logic [7:0]  we;
        logic [31:0] base;
        logic [7:0]  stp;
        logic [31:0] wbase;
        logic [7:0]  exp_ready;
        logic [15:0] exp_conf;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] data;
    } sb_t;

    vec_t        vecs [11];
    sb_t         sb [$];
    logic [31:0] exp_mem [logic [31:0]];
    int          n_cmp;
    int          n_fail;

    ram_port_arbiter #(
        .N_REQ(NR), .N_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .ram_en         (ram_en),
        .ram_we         (ram_we),
        .ram_addr       (ram_addr),
        .ram_d          (ram_d),
        .ram_q          (ram_q),
        .conflict_count (conflict_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : init_val(a);
    endfunction

    always_comb begin
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW]  = addr_a[i];
            req_wdata[i*DW +: DW] = wdata_a[i];
        end
    end

    // Behavioural RAM: combinational read, write at the edge.
    always_comb begin
        ram_q = '0;
        for (int p = 0; p < NP; p++) ram_q[p*DW +: DW] = mem[ram_addr[p*AW +: 13]];
    end

    always @(posedge clock) begin
        if (preload) begin
            for (int k = 0; k < 8192; k++) mem[k] <= init_val(32'(k));
        end else begin
            for (int p = 0; p < NP; p++)
                if (ram_en && ram_we[p]) mem[ram_addr[p*AW +: 13]] <= ram_d[p*DW +: DW];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_vec(input vec_t v);
        req_valid = v.valid;
        req_we    = v.we;
        for (int i = 0; i < NR; i++) begin
            addr_a[i]  = v.base + 32'(i) * 32'(v.stp);
            wdata_a[i] = v.wbase + 32'(i);
        end
    endtask

    // One cycle: check grants, predict reads/writes, clock, then check responses.
    task automatic step(input logic [7:0] exp_rdy, input string name);
        logic [7:0] exp_v;
        sb_t        e;
        #1;
        check({name, " ready"}, 32'(req_ready), 32'(exp_rdy));
        for (int i = 0; i < NR; i++)
            if (exp_rdy[i] && !req_we[i]) sb.push_back('{i, model_rd(addr_a[i])});
        for (int i = 0; i < NR; i++)
            if (exp_rdy[i] && req_we[i]) exp_mem[addr_a[i]] = wdata_a[i];
        @(posedge clock);
        @(negedge clock);
        exp_v = '0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            exp_v[e.idx] = 1'b1;
            check($sformatf("%s rdata%0d", name, e.idx), resp_rdata[e.idx*DW +: DW], e.data);
        end
        check({name, " resp_valid"}, 32'(resp_valid), 32'(exp_v));
    endtask

    task automatic reset_cycle(input string name);
        reset = 1'b1;
        #1;
        check({name, " ready"}, 32'(req_ready), 32'd0);
        check({name, " ram_en"}, 32'(ram_en), 32'd0);
        @(posedge clock);
        @(negedge clock);
        check({name, " resp_valid"}, 32'(resp_valid), 32'd0);
        check({name, " conflict"}, 32'(conflict_count), 32'd0);
        sb.delete();
        reset = 1'b0;
    endtask

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        reset   = 1'b1;
        preload = 1'b1;
        req_valid = '1;
        req_we    = '0;
        for (int i = 0; i < NR; i++) begin
            addr_a[i]  = 32'(i);
            wdata_a[i] = 32'd0;
        end

        // Reset held two cycles with every requester valid.
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        preload = 1'b0;
        check("rst ready", 32'(req_ready), 32'd0);
        check("rst ram_we", 32'(ram_we), 32'd0);
        check("rst ram_en", 32'(ram_en), 32'd0);
        check("rst ram_addr", 32'(|ram_addr), 32'd0);
        check("rst resp_valid", 32'(resp_valid), 32'd0);
        check("rst conflict", 32'(conflict_count), 32'd0);
        reset = 1'b0;

        //          valid   we      base     stp   wbase       ready   conf
        vecs[0]  = '{8'hFF, 8'h00, 32'd256,  8'd4, 32'h1000, 8'h0F, 16'd0};
        vecs[1]  = '{8'hF0, 8'h00, 32'd256,  8'd4, 32'h1000, 8'hF0, 16'd0};
        vecs[2]  = '{8'h0F, 8'h0F, 32'd512,  8'd0, 32'h2000, 8'h01, 16'd3};
        vecs[3]  = '{8'h0F, 8'h00, 32'd512,  8'd0, 32'h2000, 8'h0F, 16'd3};
        vecs[4]  = '{8'hFF, 8'hAA, 32'd768,  8'd0, 32'h3000, 8'h02, 16'd10};
        vecs[5]  = '{8'hFF, 8'h55, 32'd1024, 8'd0, 32'h4000, 8'h04, 16'd17};
        vecs[6]  = '{8'h03, 8'h02, 32'd1280, 8'd0, 32'h5000, 8'h03, 16'd17};
        vecs[7]  = '{8'h03, 8'h00, 32'd1280, 8'd0, 32'h5000, 8'h03, 16'd17};
        vecs[8]  = '{8'h00, 8'h00, 32'd0,    8'd0, 32'h0,    8'h00, 16'd17};
        vecs[9]  = '{8'hFF, 8'h0F, 32'd2000, 8'd4, 32'h6000, 8'h3C, 16'd17};
        vecs[10] = '{8'hFF, 8'h00, 32'd2000, 8'd4, 32'h6000, 8'hC3, 16'd17};

        for (int v = 0; v < 11; v++) begin
            drive_vec(vecs[v]);
            step(vecs[v].exp_ready, $sformatf("vec%0d", v));
            check($sformatf("vec%0d conflict", v), 32'(conflict_count), 32'(vecs[v].exp_conf));
        end

        // Reset in the middle of traffic drops everything.
        drive_vec('{8'hFF, 8'h00, 32'd256, 8'd4, 32'h0, 8'h00, 16'd0});
        reset_cycle("midrst");

        // Write-after-write to the same address: later write waits a cycle.
        req_valid = 8'h03; req_we = 8'h03;
        addr_a[0] = 32'd2048; addr_a[1] = 32'd2048;
        wdata_a[0] = 32'hDEAD; wdata_a[1] = 32'hBEEF;
        step(8'h01, "waw");
        check("waw conflict", 32'(conflict_count), 32'd1);
        req_valid = 8'h02;
        step(8'h02, "waw retry");
        req_valid = 8'h01; req_we = 8'h00;
        step(8'h01, "waw readback");

        // Read-after-write to the same address with rr_ptr at 2.
        req_valid = 8'h02; addr_a[1] = 32'd0;
        step(8'h02, "ptr to 2");
        req_valid = 8'h0C; req_we = 8'h04;
        addr_a[2] = 32'd4096; addr_a[3] = 32'd4096; wdata_a[2] = 32'd5;
        step(8'h04, "raw");
        check("raw conflict", 32'(conflict_count), 32'd2);
        req_valid = 8'h08;
        step(8'h08, "raw retry");
        req_valid = 8'h00;
        step(8'h00, "raw after");

        // Lone highest requester, then wrap of the pointer back to 0.
        reset_cycle("wraprst");
        req_valid = 8'h80; req_we = 8'h00; addr_a[7] = 32'd300; addr_a[0] = 32'd304;
        #1;
        check("wrap port0 addr", ram_addr[31:0], 32'd300);
        check("wrap port1 addr", ram_addr[63:32], 32'd0);
        check("wrap ram_we", 32'(ram_we), 32'd0);
        step(8'h80, "wrap");
        req_valid = 8'h81;
        #1;
        check("both port0 addr", ram_addr[31:0], 32'd304);
        check("both port1 addr", ram_addr[63:32], 32'd300);
        step(8'h81, "both");

        // Saturate the conflict counter: 7 deferrals per cycle.
        reset_cycle("satrst");
        drive_vec('{8'hFF, 8'hFF, 32'd6000, 8'd0, 32'h7000, 8'h00, 16'd0});
        repeat (9362) @(posedge clock);
        @(negedge clock);
        check("sat 65534", 32'(conflict_count), 32'd65534);
        @(posedge clock);
        @(negedge clock);
        check("sat ffff", 32'(conflict_count), 32'h0000FFFF);
        @(posedge clock);
        @(negedge clock);
        check("sat hold", 32'(conflict_count), 32'h0000FFFF);
        req_valid = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
